// File: rtl/period_meter_pkg.sv
// Shared types and default parameters for the period meter: FSM state encoding
// and default widths/limits used by the interface and the top.
package period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HALF1 = 2'd1,
    ST_RUN   = 2'd2,
    ST_STALL = 2'd3
  } state_e;

  localparam int CNT_W_DEF       = 27;
  localparam int TIMEOUT_DEF     = 50_000_000;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/period_meter_if.sv
// Result channel of the period meter: valid/ready handshake plus measurement
// data and status flags.
interface period_meter_if
  import period_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] half_period;
  logic [CNT_W:0]   period;
  logic             stalled;
  logic             overrun;

  modport master (
    output meas_valid, half_period, period, stalled, overrun,
    input  meas_ready
  );

  modport slave (
    input  meas_valid, half_period, period, stalled, overrun,
    output meas_ready
  );

endinterface

// File: rtl/period_meter_sync_edge_det.sv
// Synchronizes a slow asynchronous input and emits a one-cycle strobe on
// every transition (rising or falling).
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic strobe
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;

  // synchronizer chain followed by one history flop for edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_r <= '0;
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign strobe = sync_r[SYNC_STAGES-1] ^ hist_r;

endmodule

// File: rtl/period_meter.sv
// Measures clk cycles between edges of a slow input, reporting the latest
// half-period and full period over a valid/ready channel, with stall detection.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_in,
  input  logic clear,
  period_meter_if.master meas
);

  localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic             strobe_s;
  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] h_prev_r;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk     (clk),
    .reset_n (reset_n),
    .async_in(sig_in),
    .strobe  (strobe_s)
  );

  // edge counter, measurement FSM, result capture and handshake
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r          <= ST_IDLE;
      cnt_r            <= '0;
      h_prev_r         <= '0;
      meas.meas_valid  <= 1'b0;
      meas.half_period <= '0;
      meas.period      <= '0;
      meas.stalled     <= 1'b0;
      meas.overrun     <= 1'b0;
    end else if (clear) begin
      // data outputs deliberately hold their last values across a clear
      state_r         <= ST_IDLE;
      cnt_r           <= '0;
      h_prev_r        <= '0;
      meas.meas_valid <= 1'b0;
      meas.stalled    <= 1'b0;
      meas.overrun    <= 1'b0;
    end else begin
      cnt_r <= strobe_s ? ONE_C : cnt_r + ONE_C;
      if (meas.meas_valid && meas.meas_ready) begin
        meas.meas_valid <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (strobe_s) begin
            state_r <= ST_HALF1;
          end
        end
        ST_HALF1: begin
          if (strobe_s) begin
            h_prev_r <= cnt_r;
            state_r  <= ST_RUN;
          end else if (cnt_r == TIMEOUT_C) begin
            meas.stalled <= 1'b1;
            state_r      <= ST_STALL;
          end
        end
        ST_RUN: begin
          if (strobe_s) begin
            meas.half_period <= cnt_r;
            meas.period      <= {1'b0, cnt_r} + {1'b0, h_prev_r};
            h_prev_r         <= cnt_r;
            meas.meas_valid  <= 1'b1;
            if (meas.meas_valid && !meas.meas_ready) begin
              meas.overrun <= 1'b1;
            end
          end else if (cnt_r == TIMEOUT_C) begin
            meas.stalled <= 1'b1;
            state_r      <= ST_STALL;
          end
        end
        ST_STALL: begin
          // the reviving edge starts a fresh measurement with no history
          if (strobe_s) begin
            meas.stalled <= 1'b0;
            h_prev_r     <= '0;
            state_r      <= ST_HALF1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: table of symmetric/asymmetric waves plus
// hand-written stall, overrun, same-cycle acceptance and reset/clear sequences.
module tb_period_meter;

  localparam int CNT_W = 8;
  localparam int TMO   = 20;
  localparam int SYNC  = 2;

  typedef struct {
    int hi;
    int lo;
    int reps;
    int n_res;
    int half_even;
    int half_odd;
    int per;
  } vec_t;

  typedef struct {
    int h;
    int p;
  } res_t;

  logic clk;
  logic reset_n;
  logic sig_in;
  logic clear;
  int   n_vec;
  int   n_err;
  res_t q[$];
  vec_t vecs[5];

  period_meter_if #(.CNT_W(CNT_W)) meas ();

  period_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TMO),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .sig_in (sig_in),
    .clear  (clear),
    .meas   (meas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record every accepted result
  always @(negedge clk) begin
    if (reset_n && !clear && meas.meas_valid && meas.meas_ready) begin
      q.push_back('{int'(meas.half_period), int'(meas.period)});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      sig_in = 1'b1;
      step(hi);
      sig_in = 1'b0;
      step(lo);
    end
  endtask

  task automatic restart();
    sig_in = 1'b0;
    step(4);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(2);
  endtask

  task automatic chk_out(input string name, input int v, input int h, input int p);
    chk({name, " valid"}, int'(meas.meas_valid), v);
    chk({name, " half"}, int'(meas.half_period), h);
    chk({name, " period"}, int'(meas.period), p);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    // hi, lo, reps, results, half(even idx), half(odd idx), period
    vecs[0] = '{5, 5, 4, 6, 5, 5, 10};
    vecs[1] = '{3, 7, 4, 6, 7, 3, 10};
    vecs[2] = '{8, 8, 3, 4, 8, 8, 16};
    vecs[3] = '{1, 1, 4, 6, 1, 1, 2};
    vecs[4] = '{20, 2, 2, 2, 2, 20, 22};

    reset_n         = 1'b0;
    sig_in          = 1'b0;
    clear           = 1'b0;
    meas.meas_ready = 1'b0;
    step(3);
    chk_out("reset", 0, 0, 0);
    chk("reset stalled", int'(meas.stalled), 0);
    chk("reset overrun", int'(meas.overrun), 0);
    reset_n = 1'b1;
    step(2);

    for (int v = 0; v < 5; v++) begin
      restart();
      q.delete();
      meas.meas_ready = 1'b1;
      wave(vecs[v].hi, vecs[v].lo, vecs[v].reps);
      step(6);
      chk($sformatf("vec%0d count", v), q.size(), vecs[v].n_res);
      for (int k = 0; k < q.size() && k < vecs[v].n_res; k++) begin
        chk($sformatf("vec%0d res%0d half", v, k), q[k].h,
            (k % 2 == 0) ? vecs[v].half_even : vecs[v].half_odd);
        chk($sformatf("vec%0d res%0d period", v, k), q[k].p, vecs[v].per);
      end
      chk($sformatf("vec%0d overrun", v), int'(meas.overrun), 0);
      chk($sformatf("vec%0d stalled", v), int'(meas.stalled), 0);
    end

    // stall: exact assertion cycle, revival edge, two more edges before a result
    restart();
    meas.meas_ready = 1'b1;
    sig_in = 1'b1;
    step(5);
    sig_in = 1'b0;
    step(22);
    chk("stall before", int'(meas.stalled), 0);
    step(1);
    chk("stall at", int'(meas.stalled), 1);
    sig_in = 1'b1;
    step(2);
    chk("stall hold", int'(meas.stalled), 1);
    step(1);
    chk("stall cleared", int'(meas.stalled), 0);
    step(2);
    sig_in = 1'b0;
    step(5);
    sig_in = 1'b1;
    step(2);
    chk("stall no early result", int'(meas.meas_valid), 0);
    step(1);
    chk_out("stall resume", 1, 5, 10);

    // overrun: second result overwrites unaccepted first
    restart();
    meas.meas_ready = 1'b0;
    sig_in = 1'b1;
    step(5);
    sig_in = 1'b0;
    step(4);
    sig_in = 1'b1;
    step(3);
    chk_out("ovr first", 1, 4, 9);
    chk("ovr first flag", int'(meas.overrun), 0);
    step(3);
    sig_in = 1'b0;
    step(3);
    chk_out("ovr second", 1, 6, 10);
    chk("ovr flag", int'(meas.overrun), 1);
    meas.meas_ready = 1'b1;
    step(1);
    meas.meas_ready = 1'b0;
    chk("ovr accepted valid", int'(meas.meas_valid), 0);
    step(1);
    chk("ovr sticky", int'(meas.overrun), 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk_out("ovr after clear", 0, 6, 10);
    chk("ovr cleared", int'(meas.overrun), 0);

    // new result in the same cycle the pending one is accepted
    restart();
    meas.meas_ready = 1'b0;
    sig_in = 1'b1;
    step(5);
    sig_in = 1'b0;
    step(5);
    sig_in = 1'b1;
    step(3);
    chk_out("same first", 1, 5, 10);
    step(4);
    sig_in = 1'b0;
    step(2);
    meas.meas_ready = 1'b1;
    step(1);
    meas.meas_ready = 1'b0;
    chk_out("same load", 1, 7, 12);
    chk("same overrun", int'(meas.overrun), 0);
    step(1);
    chk("same pending", int'(meas.meas_valid), 1);
    meas.meas_ready = 1'b1;
    step(1);
    meas.meas_ready = 1'b0;
    chk("same drained", int'(meas.meas_valid), 0);

    // reset (m=0) or clear (m=1) mid-RUN, then resume at N=8
    for (int m = 0; m < 2; m++) begin
      restart();
      meas.meas_ready = 1'b1;
      wave(5, 5, 2);
      if (m == 0) reset_n = 1'b0;
      else clear = 1'b1;
      step(1);
      if (m == 0) chk_out("rst mid", 0, 0, 0);
      else chk_out("clr mid", 0, 5, 10);
      step(2);
      reset_n = 1'b1;
      clear   = 1'b0;
      step(2);
      sig_in = 1'b1;
      step(8);
      sig_in = 1'b0;
      step(8);
      sig_in = 1'b1;
      step(2);
      chk($sformatf("resume%0d early", m), int'(meas.meas_valid), 0);
      step(1);
      chk_out($sformatf("resume%0d", m), 1, 8, 16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
